muu_resp_arbiter: RTL and testbench
===================================

Name: muu_resp_arbiter

Overview:
- Packet-aware round-robin arbiter that merges the response streams of NUM_PORTS value-get pipelines into one network-facing response stream.
- Each input carries {meta, 512-bit word} data, user id and last; a grant is held for a whole packet, from the first word to the word with last=1.
- Sits between the per-pipeline value-get units and the TCP/IP transmit path.
- Output is fully registered, so timing closes at the 512-bit width.

Parameters:
NUM_PORTS, 4, number of requesting pipelines (2..8)
DATA_WIDTH, 608, width of one response beat (META_WIDTH 96 + 512)
USER_WIDTH, 8, width of the user/session id carried with each beat
SRC_WIDTH, 3, width of the source index output (must be >= clog2(NUM_PORTS))

Ports:
clk  in  1  clock
rst  in  1  reset
in_data  in  NUM_PORTS*DATA_WIDTH  concatenated input beats, port i at [i*DATA_WIDTH +: DATA_WIDTH]
in_user  in  NUM_PORTS*USER_WIDTH  concatenated user ids
in_valid  in  NUM_PORTS  per-port valid
in_last  in  NUM_PORTS  per-port end-of-packet
in_ready  out  NUM_PORTS  per-port ready
out_data  out  DATA_WIDTH  granted beat
out_user  out  USER_WIDTH  user id of granted beat
out_src  out  SRC_WIDTH  index of the port that produced the beat
out_valid  out  1  output valid
out_last  out  1  output end-of-packet
out_ready  in  1  downstream ready
stat_pkts  out  32  packets forwarded (optional feature)
stat_words  out  32  beats forwarded (optional feature)

Interface rules:
- One clock, clk.
- Reset is synchronous and active-high on rst.
- A transfer occurs when valid && ready on the same edge.

Behaviour:
Reset values:
- out_valid=0, out_last=0, out_data=0, out_user=0, out_src=0, in_ready=0.
- state=ST_IDLE, grant=0, rr_ptr=0, stat_*=0.
- An rst asserted mid-packet drops that packet immediately; no partial flush is performed.

States:
- ST_IDLE:
  - in_ready=0 on all ports.
  - If any in_valid, grant = first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_PORTS; go to ST_BUSY next cycle.
  - No in_valid: stay in ST_IDLE.
- ST_BUSY:
  - in_ready[grant] = (!out_valid || out_ready); all other in_ready = 0.
  - in_ready is combinational from registered state and out_ready.
  - On a transfer on port grant: out_data, out_user, out_last, out_src=grant are registered and out_valid=1 on the next cycle.
  - If the transferred beat has last=1: state becomes ST_IDLE and rr_ptr = (grant+1) mod NUM_PORTS.

Output register:
- If out_valid && out_ready and there is no new transfer, out_valid clears.
- While out_valid && !out_ready, all out_* are held stable.

Latency and throughput:
- Request seen in ST_IDLE at cycle k → in_ready high at k+1 → beat on output at k+2.
- Steady state is 1 beat/cycle within a packet.
- Exactly one idle arbitration cycle between packets.

Boundary conditions:
- Granted port deasserts in_valid mid-packet: the grant is held indefinitely and no other port is served.
- Single-beat packet (valid && last on the first beat) is legal.
- Requester at rr_ptr that is not valid is skipped without penalty.
- Only one port requesting: it is served back-to-back, with the one-cycle gap between packets.
- in_last on a beat that is not transferred is ignored.
- NUM_PORTS=1 degenerates to a registered pass-through with the inter-packet gap.

Optional Feature:
MUU_RESP_ARB_STATS_EN
- Defined:
  - stat_words increments on every output transfer (out_valid && out_ready).
  - stat_pkts increments on every output transfer with out_last=1.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Both reset to 0.
- Undefined:
  - stat_pkts and stat_words are tied to 0; the ports remain present so the interface is identical.
  - No counter logic is synthesized.

Test Plan:
- Reset, then port 2 sends 3 beats (last on beat 3), out_ready=1 → out_valid on cycles k+2..k+4, out_src=2, out_last only on the 3rd beat, then one idle cycle.
- All 4 ports hold 2-beat packets continuously, out_ready=1 → packet order 0,1,2,3,0; packets never interleave; each packet is followed by exactly one bubble.
- Port 1 mid-packet with out_ready held 0 for 5 cycles → out_data/out_user/out_last stable for all 5 cycles, in_ready[1]=0, no beat lost or duplicated.
- Port 0 drops in_valid for 4 cycles mid-packet while port 3 is valid → port 3 gets no in_ready until port 0's last beat is transferred.
- Assert rst during beat 2 of a 4-beat packet → next cycle out_valid=0, in_ready=0, rr_ptr=0; a new request from port 0 is then granted first.
- With MUU_RESP_ARB_STATS_EN, forward 3 packets of 1, 2 and 5 beats → stat_pkts=3, stat_words=8. Preload stat_words to 0xFFFFFFFF via force, forward 1 beat → reads 0.

Source files
------------

// File: rtl/muu_resp_arbiter.sv
// muu_resp_arbiter
//   Packet-aware round-robin arbiter. It merges the response streams of
//   NUM_PORTS value-get pipelines into one network-facing stream. A grant is
//   held from the first beat of a packet until the beat with last=1. The
//   output stage is fully registered.
//
//   Optional statistics counters are built only when MUU_RESP_ARB_STATS_EN is
//   defined. Otherwise stat_pkts/stat_words are tied to zero.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_data      NUM_PORTS beats, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_user      NUM_PORTS user ids, port i at [i*USER_WIDTH +: USER_WIDTH]
//   in_valid     per-port valid
//   in_last      per-port end-of-packet
//   in_ready     per-port ready (only the granted port, only in ST_BUSY)
//   out_data     registered granted beat
//   out_user     registered user id
//   out_src      index of the port that produced the beat
//   out_valid    output valid
//   out_last     output end-of-packet
//   out_ready    downstream ready
//   stat_pkts    packets forwarded (wraps at 2^32)
//   stat_words   beats forwarded (wraps at 2^32)
module muu_resp_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 608,
  parameter int USER_WIDTH = 8,
  parameter int SRC_WIDTH  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  in_user,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS-1:0]             in_last,
  output logic [NUM_PORTS-1:0]             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [USER_WIDTH-1:0]            out_user,
  output logic [SRC_WIDTH-1:0]             out_src,
  output logic                             out_valid,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic [31:0]                      stat_pkts,
  output logic [31:0]                      stat_words
);

  localparam int          IDXW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned NP   = NUM_PORTS;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        grant_q, grant_d;
  logic [IDXW-1:0]        rr_q, rr_d;

  logic                   arb_found;
  logic [IDXW-1:0]        arb_sel;
  int unsigned            cand;

  logic [DATA_WIDTH-1:0]  sel_data;
  logic [USER_WIDTH-1:0]  sel_user;
  logic                   sel_valid;
  logic                   sel_last;

  logic                   can_accept;
  logic                   xfer;

  // Round-robin search: the first valid port starting at rr_q and wrapping.
  // Candidate offsets are tried in priority order. The inner loop keeps the
  // port index constant so no variable bit-select is needed.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NP; off++) begin
      cand = 32'(rr_q) + off;
      if (cand >= NP) cand = cand - NP;
      for (int unsigned p = 0; p < NP; p++) begin
        if (!arb_found && (p == cand) && in_valid[p]) begin
          arb_found = 1'b1;
          arb_sel   = IDXW'(p);
        end
      end
    end
  end

  // Mux the granted port's beat.
  always_comb begin
    sel_data  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned p = 0; p < NP; p++) begin
      if (IDXW'(p) == grant_q) begin
        sel_data  = in_data[p*DATA_WIDTH +: DATA_WIDTH];
        sel_user  = in_user[p*USER_WIDTH +: USER_WIDTH];
        sel_valid = in_valid[p];
        sel_last  = in_last[p];
      end
    end
  end

  // Next state, grant, round-robin pointer and in_ready.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    in_ready   = '0;
    can_accept = !out_valid || out_ready;
    xfer       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d = arb_sel;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int unsigned p = 0; p < NP; p++) begin
          if (IDXW'(p) == grant_q) in_ready[p] = can_accept;
        end
        xfer = sel_valid && can_accept;
        if (xfer && sel_last) begin
          state_d = ST_IDLE;
          rr_d    = (grant_q == IDXW'(NP - 1)) ? '0 : grant_q + IDXW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Output register. It loads on a transfer, clears when the downstream
  // accepts with nothing new, and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_last  <= sel_last;
      out_data  <= sel_data;
      out_user  <= sel_user;
      out_src   <= SRC_WIDTH'(grant_q);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUU_RESP_ARB_STATS_EN
  logic [31:0] stat_pkts_q;
  logic [31:0] stat_words_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q  <= '0;
      stat_words_q <= '0;
    end else if (out_valid && out_ready) begin
      stat_words_q <= stat_words_q + 32'd1;
      if (out_last) stat_pkts_q <= stat_pkts_q + 32'd1;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_words = stat_words_q;
`else
  assign stat_pkts  = '0;
  assign stat_words = '0;
`endif

endmodule

// File: tb/tb_muu_resp_arbiter.sv
// Testbench for muu_resp_arbiter. It runs directed scenarios followed by a
// randomized phase. The reference model predicts every output and every
// in_ready value from the arbitration rules: a per-port packet queue, a held
// grant, a round-robin pointer and a one-entry output register.
module tb_muu_resp_arbiter;

  localparam int N  = 4;
  localparam int DW = 608;
  localparam int UW = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N*UW-1:0] in_user;
  logic [N-1:0]    in_valid, in_last, in_ready;
  logic [DW-1:0]   out_data;
  logic [UW-1:0]   out_user;
  logic [SW-1:0]   out_src;
  logic            out_valid, out_last, out_ready;
  logic [31:0]     stat_pkts, stat_words;

  always #5 clk = ~clk;

  muu_resp_arbiter #(
    .NUM_PORTS (N),
    .DATA_WIDTH(DW),
    .USER_WIDTH(UW),
    .SRC_WIDTH (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_user   (in_user),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_user  (out_user),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .stat_pkts (stat_pkts),
    .stat_words(stat_words)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus state: each port has a queue of packet lengths.
  int            q[N][$];
  int            rem[N];
  bit            gate[N];
  bit            rand_v, rand_or, or_hold;
  logic [DW-1:0] d[N];
  logic [UW-1:0] u[N];
  logic [N-1:0]  v, l;
  int            src_log[$];

  // Reference model.
  bit            m_busy;
  int            m_grant, m_rr, m_os;
  logic          m_ov, m_ol;
  logic [DW-1:0] m_od;
  logic [UW-1:0] m_ou;
  logic [31:0]   m_pkts, m_words;

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i += 32) r[i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_rr = 0; m_os = 0;
    m_ov = 0; m_ol = 0; m_od = '0; m_ou = '0;
    m_pkts = '0; m_words = '0;
  endtask

  // One clock cycle: drive inputs, check the DUT against the model, then
  // advance the model and the drivers across the clock edge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    bit           xf, found;
    int           g, c;
    for (int p = 0; p < N; p++) begin
      if (rem[p] == 0 && q[p].size() > 0) begin
        rem[p] = q[p].pop_front();
        d[p] = rand_beat();
        u[p] = UW'($urandom);
      end
      v[p] = (rem[p] > 0) && gate[p] && (!rand_v || $urandom_range(0, 3) != 0);
      l[p] = v[p] ? (rem[p] == 1) : 1'($urandom_range(0, 1));
      in_data[p*DW +: DW] = d[p];
      in_user[p*UW +: UW] = u[p];
    end
    in_valid  = v;
    in_last   = l;
    out_ready = rand_or ? ($urandom_range(0, 3) != 0) : !or_hold;
    #1;
    exp_rdy = '0;
    if (m_busy) exp_rdy[m_grant] = !m_ov || out_ready;
    chk("in_ready",  in_ready,  exp_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("out_last",  out_last,  m_ol);
    chk("out_data",  out_data,  m_od);
    chk("out_user",  out_user,  m_ou);
    chk("out_src",   out_src,   SW'(m_os));
`ifdef MUU_RESP_ARB_STATS_EN
    chk("stat_pkts",  stat_pkts,  m_pkts);
    chk("stat_words", stat_words, m_words);
`else
    chk("stat_pkts",  stat_pkts,  32'd0);
    chk("stat_words", stat_words, 32'd0);
`endif
    if (out_valid && out_ready && out_last) src_log.push_back(int'(out_src));
    g  = m_grant;
    xf = m_busy && v[g] && (!m_ov || out_ready);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_ov && out_ready) begin
        m_words++;
        if (m_ol) m_pkts++;
      end
      if (xf) begin
        m_ov = 1; m_od = d[g]; m_ou = u[g]; m_ol = l[g]; m_os = g;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (!m_busy) begin
        found = 0;
        for (int off = 0; off < N; off++) begin
          c = (m_rr + off) % N;
          if (!found && v[c]) begin
            found = 1; m_grant = c; m_busy = 1;
          end
        end
      end else if (xf && l[g]) begin
        m_busy = 0;
        m_rr = (g + 1) % N;
      end
      if (xf) begin
        rem[g]--;
        d[g] = rand_beat();
        u[g] = UW'($urandom);
      end
    end
    @(negedge clk);
  endtask

  function automatic bit work_left();
    bit any = m_busy || m_ov;
    for (int p = 0; p < N; p++) any |= (rem[p] > 0) || (q[p].size() > 0);
    return any;
  endfunction

  task automatic drain(input int maxc);
    int c = 0;
    while (work_left() && c < maxc) begin
      step();
      c++;
    end
    chk("drain_timeout", c < maxc, 1'b1);
  endtask

  task automatic do_reset();
    for (int p = 0; p < N; p++) begin
      q[p].delete();
      rem[p] = 0;
      gate[p] = 1;
    end
    rand_v = 0; rand_or = 0; or_hold = 0;
    rst = 1;
    step();
    rst = 0;
    src_log.delete();
  endtask

  initial begin
    rst = 1; in_data = '0; in_user = '0; in_valid = '0; in_last = '0; out_ready = 1;
    for (int p = 0; p < N; p++) begin
      rem[p] = 0; gate[p] = 1; d[p] = '0; u[p] = '0;
    end
    v = '0; l = '0; rand_v = 0; rand_or = 0; or_hold = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset state, then a single 3-beat packet from port 2.
    do_reset();
    q[2].push_back(3);
    drain(50);
    step();
    chk("t1_npkts", src_log.size(), 1);
    chk("t1_src", src_log[0], 2);

    // All ports with 2-beat packets: order 0,1,2,3,0.
    do_reset();
    q[0].push_back(2); q[0].push_back(2);
    for (int p = 1; p < N; p++) q[p].push_back(2);
    drain(100);
    chk("t2_npkts", src_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_order", src_log[i], i % N);

    // Port 1 stalled by the downstream for 5 cycles mid-packet.
    do_reset();
    q[1].push_back(4);
    repeat (4) step();
    or_hold = 1;
    repeat (5) begin
      step();
      chk("t3_rdy1", in_ready[1], 1'b0);
    end
    or_hold = 0;
    drain(50);
    chk("t3_npkts", src_log.size(), 1);

    // Port 0 drops valid mid-packet while port 3 waits.
    do_reset();
    q[0].push_back(4);
    q[3].push_back(2);
    repeat (3) step();
    gate[0] = 0;
    repeat (4) begin
      step();
      chk("t4_rdy3", in_ready[3], 1'b0);
    end
    gate[0] = 1;
    drain(50);
    chk("t4_npkts", src_log.size(), 2);
    chk("t4_first", src_log[0], 0);
    chk("t4_second", src_log[1], 3);

    // Reset during beat 2 of a 4-beat packet; the round-robin pointer restarts at 0.
    do_reset();
    q[1].push_back(1);
    drain(30);
    q[2].push_back(4);
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    for (int p = 0; p < N; p++) begin
      q[p].delete();
      rem[p] = 0;
    end
    src_log.delete();
    chk("t5_ov", out_valid, 1'b0);
    chk("t5_rdy", in_ready, '0);
    q[0].push_back(1);
    q[3].push_back(1);
    drain(30);
    chk("t5_first", src_log[0], 0);

    // Statistics: packets of 1, 2 and 5 beats, then wrap of stat_words.
    do_reset();
    q[0].push_back(1); q[0].push_back(2); q[0].push_back(5);
    drain(60);
`ifdef MUU_RESP_ARB_STATS_EN
    chk("t6_pkts", stat_pkts, 32'd3);
    chk("t6_words", stat_words, 32'd8);
    force dut.stat_words_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_words_q;
    m_words = 32'hFFFF_FFFF;
    q[1].push_back(1);
    drain(30);
    chk("t6_wrap", stat_words, 32'd0);
`else
    chk("t6_pkts_off", stat_pkts, 32'd0);
`endif

    // Random traffic with random valid gaps and backpressure.
    do_reset();
    rand_v = 1;
    rand_or = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (rem[p] == 0 && q[p].size() == 0 && $urandom_range(0, 7) == 0)
          q[p].push_back(int'($urandom_range(1, 6)));
      end
      step();
    end
    drain(3000);
    rand_v = 0;
    rand_or = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
